// File: rtl/hex_display_arbiter.sv
// Arbitrates the 4-digit hex display between the CPU (Avalon-MM slave) and the
// game hardware value path; a hardware update owns the display for a hold window.
module hex_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] hw_value,
  input  logic        hw_valid,
  output logic [15:0] out_port,
  output logic        hex_blank,
  output logic        hw_owner
);

  typedef enum logic {
    CPU_SHOW = 1'b0,
    HW_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        cpu_value_q, cpu_value_d;
  logic               force_q, force_d;
  logic               blank_q, blank_d;
  logic [15:0]        hw_latch_q, hw_latch_d;
  logic [15:0]        event_q, event_d;
  logic [15:0]        out_q, out_d;
  logic               hex_blank_q, hex_blank_d;
  logic               owner_q, owner_d;

  logic wr_en, wr_value, wr_ctrl, wr_event;
  logic unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign wr_value     = wr_en && (address == 2'd0);
  assign wr_ctrl      = wr_en && (address == 2'd1);
  assign wr_event     = wr_en && (address == 2'd3);
  assign unused_wdata = ^writedata[31:16];

  // Register file next-state
  always_comb begin
    cpu_value_d = cpu_value_q;
    force_d     = force_q;
    blank_d     = blank_q;
    hw_latch_d  = hw_latch_q;
    event_d     = event_q;
    if (wr_value) begin
      cpu_value_d = writedata[15:0];
    end
    if (wr_ctrl) begin
      force_d = writedata[0];
      blank_d = writedata[1];
    end
    if (hw_valid) begin
      hw_latch_d = hw_value;
    end
    // A clearing write beats a coincident hw_valid, so that pulse is not counted.
    if (wr_event) begin
      event_d = '0;
    end else if (hw_valid) begin
      event_d = event_q + 16'd1;
    end
  end

  // Arbitration: uses the post-write force bit and CPU value so a same-edge
  // ctrl or addr0 write is seen on the edge it lands.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    owner_d     = owner_q;
    hex_blank_d = blank_d;
    unique case (state_q)
      CPU_SHOW: begin
        if (hw_valid && !force_d) begin
          state_d = HW_HOLD;
          cnt_d   = RELOAD;
          out_d   = hw_value;
          owner_d = 1'b1;
        end else begin
          out_d   = cpu_value_d;
          owner_d = 1'b0;
        end
      end
      HW_HOLD: begin
        if (force_d) begin
          state_d = CPU_SHOW;
          cnt_d   = '0;
          out_d   = cpu_value_d;
          owner_d = 1'b0;
        end else if (hw_valid) begin
          cnt_d   = RELOAD;
          out_d   = hw_value;
          owner_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = CPU_SHOW;
          out_d   = cpu_value_d;
          owner_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          out_d   = hw_latch_q;
          owner_d = 1'b1;
        end
      end
      default: begin
        state_d = CPU_SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CPU_SHOW;
      cnt_q       <= '0;
      cpu_value_q <= '0;
      force_q     <= 1'b0;
      blank_q     <= 1'b0;
      hw_latch_q  <= '0;
      event_q     <= '0;
      out_q       <= '0;
      hex_blank_q <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_value_q <= cpu_value_d;
      force_q     <= force_d;
      blank_q     <= blank_d;
      hw_latch_q  <= hw_latch_d;
      event_q     <= event_d;
      out_q       <= out_d;
      hex_blank_q <= hex_blank_d;
      owner_q     <= owner_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata = {16'h0000, cpu_value_q};
      2'd1:    readdata = {30'h0, blank_q, force_q};
      2'd2:    readdata = {hw_latch_q, 15'h0, owner_q};
      2'd3:    readdata = {16'h0000, event_q};
      default: readdata = '0;
    endcase
  end

  assign out_port  = out_q;
  assign hex_blank = hex_blank_q;
  assign hw_owner  = owner_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: vector table plus hand-written
// hold, force, blank, reset and event-count sequences, checked via a queue.
module tb_hex_display_arbiter;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] hw_value;
  logic        hw_valid;
  logic [15:0] out_port;
  logic        hex_blank;
  logic        hw_owner;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        hv;
    logic [15:0] hval;
    logic [1:0]  raddr;
    logic [15:0] exp_out;
    logic        exp_owner;
    logic        exp_blank;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  hex_display_arbiter #(
    .HOLD_CYCLES(N),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .hw_value(hw_value),
    .hw_valid(hw_valid),
    .out_port(out_port),
    .hex_blank(hex_blank),
    .hw_owner(hw_owner)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] a,
                              input logic [31:0] d, input logic hv, input logic [15:0] hval,
                              input logic [1:0] ra, input logic [15:0] eo, input logic eown,
                              input logic eb, input logic [31:0] erd);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = a; v.wdata = d; v.hv = hv; v.hval = hval;
    v.raddr = ra; v.exp_out = eo; v.exp_owner = eown; v.exp_blank = eb; v.exp_rd = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered at posedge+2 (or later, before the next edge); returns at posedge+2.
  task automatic step(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    chipselect = v.wr;
    write_n    = !v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    hw_valid   = v.hv;
    hw_value   = v.hval;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    hw_valid   = 1'b0;
    address    = v.raddr;
    #1;
    e = exp_q.pop_front();
    check({e.name, ".out_port"},  {16'h0, out_port},  {16'h0, e.exp_out});
    check({e.name, ".hw_owner"},  {31'h0, hw_owner},  {31'h0, e.exp_owner});
    check({e.name, ".hex_blank"}, {31'h0, hex_blank}, {31'h0, e.exp_blank});
    check({e.name, ".readdata"},  readdata,           e.exp_rd);
  endtask

  function automatic vec_t idle(input string nm, input logic [1:0] ra, input logic [15:0] eo,
                                input logic eown, input logic eb, input logic [31:0] erd);
    return mk(nm, 1'b0, 2'd0, 32'h0, 1'b0, 16'h0, ra, eo, eown, eb, erd);
  endfunction

  initial begin
    tbl.push_back(mk("wr_cpu",      1, 2'd0, 32'h0000_1234, 0, 16'h0,    2'd0, 16'h1234, 0, 0, 32'h0000_1234));
    tbl.push_back(mk("wr_cpu_hi",   1, 2'd0, 32'hFFFF_9876, 0, 16'h0,    2'd0, 16'h9876, 0, 0, 32'h0000_9876));
    tbl.push_back(mk("wr_cpu_back", 1, 2'd0, 32'h0000_1234, 0, 16'h0,    2'd0, 16'h1234, 0, 0, 32'h0000_1234));
    tbl.push_back(mk("wr_ctrl_hi",  1, 2'd1, 32'hFFFF_FFFC, 0, 16'h0,    2'd1, 16'h1234, 0, 0, 32'h0000_0000));
    tbl.push_back(mk("wr_ro",       1, 2'd2, 32'hDEAD_BEEF, 0, 16'h0,    2'd2, 16'h1234, 0, 0, 32'h0000_0000));
    tbl.push_back(mk("hv_ab",       0, 2'd0, 32'h0,         1, 16'h00AB, 2'd2, 16'h00AB, 1, 0, 32'h00AB_0001));

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    hw_value   = '0;
    hw_valid   = 1'b0;
    #2;
    check("rst.out_port",  {16'h0, out_port},  32'h0);
    check("rst.hw_owner",  {31'h0, hw_owner},  32'h0);
    check("rst.hex_blank", {31'h0, hex_blank}, 32'h0);
    check("rst.readdata",  readdata,           32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Hold window: owner high for exactly N cycles in total.
    for (int i = 1; i < N; i++)
      step(idle($sformatf("hold_ab_%0d", i), 2'd3, 16'h00AB, 1, 0, 32'h1));
    step(idle("hold_ab_end", 2'd0, 16'h1234, 0, 0, 32'h0000_1234));

    // Two pulses at t=0 and t=5: display held until t=13.
    step(mk("clr_evt", 1, 2'd3, 32'h0, 0, 16'h0, 2'd3, 16'h1234, 0, 0, 32'h0));
    step(mk("p_t0", 0, 2'd0, 32'h0, 1, 16'h0001, 2'd2, 16'h0001, 1, 0, 32'h0001_0001));
    for (int t = 1; t < 5; t++)
      step(idle($sformatf("p_t%0d", t), 2'd3, 16'h0001, 1, 0, 32'h1));
    step(mk("p_t5", 0, 2'd0, 32'h0, 1, 16'h0002, 2'd3, 16'h0002, 1, 0, 32'h2));
    for (int t = 6; t < 13; t++)
      step(idle($sformatf("p_t%0d", t), 2'd2, 16'h0002, 1, 0, 32'h0002_0001));
    step(idle("p_t13", 2'd3, 16'h1234, 0, 0, 32'h2));

    // Same-cycle CPU write and hw_valid: hardware wins, CPU value after hold.
    step(mk("both", 1, 2'd0, 32'h0000_5555, 1, 16'h0AAA, 2'd0, 16'h0AAA, 1, 0, 32'h0000_5555));
    for (int i = 1; i < N; i++)
      step(idle($sformatf("both_%0d", i), 2'd2, 16'h0AAA, 1, 0, 32'h0AAA_0001));
    step(idle("both_end", 2'd2, 16'h5555, 0, 0, 32'h0AAA_0000));

    // CPU write during hold, then force_cpu.
    step(mk("f_hv", 0, 2'd0, 32'h0, 1, 16'h0BBB, 2'd2, 16'h0BBB, 1, 0, 32'h0BBB_0001));
    step(mk("f_cpuwr", 1, 2'd0, 32'h0000_6666, 0, 16'h0, 2'd0, 16'h0BBB, 1, 0, 32'h0000_6666));
    step(mk("f_force", 1, 2'd1, 32'h1, 0, 16'h0, 2'd1, 16'h6666, 0, 0, 32'h1));
    step(mk("f_hv_ign", 0, 2'd0, 32'h0, 1, 16'h0CCC, 2'd2, 16'h6666, 0, 0, 32'h0CCC_0000));
    step(idle("f_idle", 2'd2, 16'h6666, 0, 0, 32'h0CCC_0000));
    step(mk("f_clear", 1, 2'd1, 32'h0, 0, 16'h0, 2'd1, 16'h6666, 0, 0, 32'h0));

    // Blank does not alter arbitration.
    step(mk("b_set", 1, 2'd1, 32'h2, 0, 16'h0, 2'd1, 16'h6666, 0, 1, 32'h2));
    step(mk("b_hv", 0, 2'd0, 32'h0, 1, 16'h0DDD, 2'd2, 16'h0DDD, 1, 1, 32'h0DDD_0001));
    step(idle("b_idle1", 2'd2, 16'h0DDD, 1, 1, 32'h0DDD_0001));
    step(idle("b_idle2", 2'd1, 16'h0DDD, 1, 1, 32'h2));

    // Asynchronous reset mid-hold, away from any clock edge.
    reset   = 1'b1;
    address = 2'd2;
    #1;
    check("mid_rst.out_port",  {16'h0, out_port},  32'h0);
    check("mid_rst.hw_owner",  {31'h0, hw_owner},  32'h0);
    check("mid_rst.hex_blank", {31'h0, hex_blank}, 32'h0);
    check("mid_rst.readdata",  readdata,           32'h0);
    #1;
    reset = 1'b0;
    step(idle("post_rst", 2'd1, 16'h0000, 0, 0, 32'h0));

    // Event counter wrap after 65536 pulses.
    step(mk("w_clr", 1, 2'd3, 32'hFFFF_FFFF, 0, 16'h0, 2'd3, 16'h0000, 0, 0, 32'h0));
    for (int i = 0; i < 65535; i++) begin
      hw_valid = 1'b1;
      hw_value = 16'(i);
      @(posedge clk);
      #2;
    end
    hw_valid = 1'b0;
    step(idle("w_ffff", 2'd3, 16'hFFFE, 1, 0, 32'h0000_FFFF));
    step(mk("w_wrap", 0, 2'd0, 32'h0, 1, 16'h1111, 2'd3, 16'h1111, 1, 0, 32'h0));

    // Clearing write coincident with hw_valid loses that pulse.
    step(mk("c_hv", 0, 2'd0, 32'h0, 1, 16'h3333, 2'd3, 16'h3333, 1, 0, 32'h1));
    step(mk("c_both", 1, 2'd3, 32'h0, 1, 16'h2222, 2'd3, 16'h2222, 1, 0, 32'h0));
    step(idle("c_after", 2'd2, 16'h2222, 1, 0, 32'h2222_0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
